// File: rtl/mux_nx1_pipe.sv
// Registered N:1 selector with valid/ready flow control, a 2-entry skid buffer,
// pipeline flush and detection of an out-of-range select.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   data_in, sel   : flattened inputs (input k at [k*WIDTH +: WIDTH]) and binary select
//   in_valid/ready : upstream handshake
//   flush          : drop every buffered entry
//   data_out       : selected, registered data
//   out_valid/ready: downstream handshake
//   sel_err        : one-cycle pulse after an accepted select >= NUM_IN
module mux_nx1_pipe #(
  parameter int              WIDTH   = 5,
  parameter int              NUM_IN  = 2,
  parameter int              SEL_W   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_sel_err;

  logic [WIDTH-1:0] w_payload;
  logic             w_oor;
  logic             w_accept;
  logic             w_emit;

  // An unmatched select falls through to RST_VAL.
  always_comb begin
    w_payload = RST_VAL;
    for (int k = 0; k < NUM_IN; k++) begin
      if (32'(sel) == k) begin
        w_payload = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_oor     = (32'(sel) >= NUM_IN);
  assign in_ready  = (r_state != S_TWO);
  assign out_valid = (r_state != S_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_emit    = out_valid && out_ready;
  assign data_out  = r_main;
  assign sel_err   = r_sel_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_EMPTY;
      r_main    <= RST_VAL;
      r_skid    <= RST_VAL;
      r_sel_err <= 1'b0;
    end else if (flush) begin
      // Main register keeps its value; only the valid state is dropped.
      r_state   <= S_EMPTY;
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_accept && w_oor;
      unique case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main  <= w_payload;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_emit) begin
            r_main <= w_payload;
          end else if (w_accept) begin
            r_skid  <= w_payload;
            r_state <= S_TWO;
          end else if (w_emit) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_emit) begin
            r_main  <= r_skid;
            r_state <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: default 5-bit 2:1 instance (A) and an
// 8-bit 3-input instance with 2-bit select and RST_VAL=AA (B).
module tb_mux_nx1_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [9:0]  a_data;
  logic        a_sel, a_iv, a_ir, a_flush, a_ov, a_ordy, a_se;
  logic [4:0]  a_dout;

  logic [23:0] b_data;
  logic [1:0]  b_sel;
  logic        b_iv, b_ir, b_flush, b_ov, b_ordy, b_se;
  logic [7:0]  b_dout;

  mux_nx1_pipe u_a (
    .clk(clk), .rst(rst), .data_in(a_data), .sel(a_sel),
    .in_valid(a_iv), .in_ready(a_ir), .flush(a_flush),
    .data_out(a_dout), .out_valid(a_ov), .out_ready(a_ordy),
    .sel_err(a_se)
  );

  mux_nx1_pipe #(
    .WIDTH(8), .NUM_IN(3), .SEL_W(2), .RST_VAL(8'hAA)
  ) u_b (
    .clk(clk), .rst(rst), .data_in(b_data), .sel(b_sel),
    .in_valid(b_iv), .in_ready(b_ir), .flush(b_flush),
    .data_out(b_dout), .out_valid(b_ov), .out_ready(b_ordy),
    .sel_err(b_se)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: per instance a 2-deep FIFO of accepted payloads,
  // the value last shown on data_out and the sel_err pulse.
  logic [7:0] m_f [2][2];
  int         m_n [2];
  logic [7:0] m_d [2];
  logic       m_e [2];
  bit         m_ok = 1'b0;

  task automatic step(int i, logic iv, logic fl, logic ordy,
                      logic [7:0] pay, logic oor, logic [7:0] rv);
    bit acc, emt;
    if (rst) begin
      m_n[i] = 0;
      m_d[i] = rv;
      m_e[i] = 1'b0;
    end else if (fl) begin
      m_n[i] = 0;
      m_e[i] = 1'b0;
    end else begin
      acc = iv && (m_n[i] < 2);
      emt = (m_n[i] > 0) && ordy;
      if (emt) begin
        m_f[i][0] = m_f[i][1];
        m_n[i]--;
      end
      if (acc) begin
        m_f[i][m_n[i]] = pay;
        m_n[i]++;
      end
      m_e[i] = acc && oor;
      if (m_n[i] > 0) m_d[i] = m_f[i][0];
    end
  endtask

  always @(posedge clk) begin
    logic [7:0] pa, pb;
    pa = {3'b0, (a_sel ? a_data[9:5] : a_data[4:0])};
    pb = (b_sel < 2'd3) ? b_data[b_sel*8 +: 8] : 8'hAA;
    step(0, a_iv, a_flush, a_ordy, pa, 1'b0, 8'h00);
    step(1, b_iv, b_flush, b_ordy, pb, (b_sel == 2'd3), 8'hAA);
    if (rst) m_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("a_in_ready",  a_ir,   m_n[0] < 2);
      chk("a_out_valid", a_ov,   m_n[0] > 0);
      chk("a_data_out",  a_dout, m_d[0]);
      chk("a_sel_err",   a_se,   m_e[0]);
      chk("b_in_ready",  b_ir,   m_n[1] < 2);
      chk("b_out_valid", b_ov,   m_n[1] > 0);
      chk("b_data_out",  b_dout, m_d[1]);
      chk("b_sel_err",   b_se,   m_e[1]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_data = {5'h03, 5'h1F}; a_sel = 1'b0; a_iv = 1'b1;
    a_flush = 1'b0; a_ordy = 1'b1;
    b_data = 24'h332211; b_sel = 2'd0; b_iv = 1'b1;
    b_flush = 1'b0; b_ordy = 1'b1;

    // Reset with in_valid high
    cyc(); cyc();
    chk("rst_dout",  a_dout, 5'h00);
    chk("rst_ov",    a_ov,   1'b0);
    chk("rst_ir",    a_ir,   1'b1);
    chk("rst_se",    a_se,   1'b0);
    chk("rst_bdout", b_dout, 8'hAA);
    rst = 1'b0; a_iv = 1'b0; b_iv = 1'b0;
    cyc();
    chk("rst_noacc", a_ov, 1'b0);

    // Streaming, sel 0,1,0
    a_iv = 1'b1; a_sel = 1'b0;
    cyc(); chk("str0", a_dout, 5'h1F);
    a_sel = 1'b1;
    cyc(); chk("str1", a_dout, 5'h03);
    a_sel = 1'b0;
    cyc(); chk("str2", a_dout, 5'h1F);
    a_iv = 1'b0;
    cyc();
    chk("str_empty_ov", a_ov, 1'b0);
    chk("str_hold",     a_dout, 5'h1F);

    // Backpressure 7, 9, then 11 waiting
    a_ordy = 1'b0; a_iv = 1'b1; a_data = 10'd7;
    cyc(); chk("bp_first", a_dout, 5'd7);
    chk("bp_ir1", a_ir, 1'b1);
    a_data = 10'd9;
    cyc(); chk("bp_ir0", a_ir, 1'b0);
    chk("bp_hold7", a_dout, 5'd7);
    a_data = 10'd11;
    cyc(); chk("bp_stall", a_dout, 5'd7);
    a_ordy = 1'b1;
    cyc(); chk("bp_emit9", a_dout, 5'd9);
    chk("bp_ir_back", a_ir, 1'b1);
    cyc(); chk("bp_emit11", a_dout, 5'd11);
    a_iv = 1'b0;
    cyc(); chk("bp_empty", a_ov, 1'b0);

    // Flush in TWO with 8 presented
    a_ordy = 1'b0; a_iv = 1'b1; a_data = 10'd4;
    cyc(); a_data = 10'd6;
    cyc(); chk("fl_two", a_ir, 1'b0);
    a_flush = 1'b1; a_data = 10'd8;
    cyc();
    chk("fl_ov", a_ov, 1'b0);
    chk("fl_ir", a_ir, 1'b1);
    chk("fl_dout", a_dout, 5'd4);
    a_flush = 1'b0; a_iv = 1'b0; a_ordy = 1'b1;
    cyc(); cyc();
    chk("fl_no8", a_ov, 1'b0);

    // Out-of-range select on B
    b_iv = 1'b1; b_sel = 2'd3;
    cyc();
    chk("oor_dout", b_dout, 8'hAA);
    chk("oor_se1",  b_se,   1'b1);
    b_sel = 2'd2;
    cyc();
    chk("oor_sel2", b_dout, 8'h33);
    chk("oor_se0",  b_se,   1'b0);
    b_sel = 2'd1;
    cyc(); chk("oor_sel1", b_dout, 8'h22);
    b_iv = 1'b0;
    cyc(); chk("oor_idle", b_se, 1'b0);
    b_iv = 1'b1; b_sel = 2'd3; b_flush = 1'b1;
    cyc();
    chk("oor_fl_se", b_se, 1'b0);
    chk("oor_fl_ov", b_ov, 1'b0);
    b_iv = 1'b0; b_flush = 1'b0;

    // Reset while A holds two entries
    a_ordy = 1'b0; a_iv = 1'b1; a_data = 10'd4;
    b_ordy = 1'b0; b_iv = 1'b1; b_sel = 2'd0;
    cyc(); a_data = 10'd6;
    cyc(); chk("mr_two", a_ir, 1'b0);
    rst = 1'b1; a_ordy = 1'b1; a_iv = 1'b0;
    b_ordy = 1'b1; b_iv = 1'b0;
    cyc();
    chk("mr_ov",    a_ov,   1'b0);
    chk("mr_dout",  a_dout, 5'h00);
    chk("mr_ir",    a_ir,   1'b1);
    chk("mr_bdout", b_dout, 8'hAA);
    rst = 1'b0;
    cyc(); cyc();
    chk("mr_none", a_ov, 1'b0);
    chk("mr_keep", a_dout, 5'h00);

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
